// File: rtl/shift_sequencer_if.sv
// Request/result bundle between the ALU issue logic and the multi-cycle shifter.
interface shift_sequencer_if;
   logic        ctrl_start;
   logic        ctrl_shiftop;
   logic [31:0] data_operandA;
   logic [4:0]  ctrl_shiftamt;
   logic [31:0] data_result;
   logic        data_resultRDY;
   logic        busy;

   modport master (
      output ctrl_start, ctrl_shiftop, data_operandA, ctrl_shiftamt,
      input  data_result, data_resultRDY, busy
   );

   modport slave (
      input  ctrl_start, ctrl_shiftop, data_operandA, ctrl_shiftamt,
      output data_result, data_resultRDY, busy
   );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle SLL/SRA: one power-of-two stage (16,8,4,2,1) per cycle, MSB first.
// Latency popcount(amt)+1 cycles; starts are ignored while busy (no queuing).
module shift_sequencer (
   input  logic              clock,
   input  logic              reset,
   shift_sequencer_if.slave  bus
);

   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

   state_t      r_state;
   logic [31:0] r_acc;
   logic [4:0]  r_rem;
   logic        r_op;
   logic [31:0] r_result;
   logic        r_rdy;

   state_t      w_state_nxt;
   logic [31:0] w_acc_nxt;
   logic [4:0]  w_rem_nxt;
   logic        w_op_nxt;
   logic [31:0] w_result_nxt;
   logic        w_rdy_nxt;
   logic [4:0]  w_step;

   // Highest set bit of the remaining amount; it doubles as the shift distance
   // and as the mask that clears that bit.
   always_comb begin
      w_step = 5'd0;
      if (r_rem[4])      w_step = 5'd16;
      else if (r_rem[3]) w_step = 5'd8;
      else if (r_rem[2]) w_step = 5'd4;
      else if (r_rem[1]) w_step = 5'd2;
      else if (r_rem[0]) w_step = 5'd1;
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_acc_nxt    = r_acc;
      w_rem_nxt    = r_rem;
      w_op_nxt     = r_op;
      w_result_nxt = r_result;
      w_rdy_nxt    = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.ctrl_start) begin
               w_acc_nxt   = bus.data_operandA;
               w_rem_nxt   = bus.ctrl_shiftamt;
               w_op_nxt    = bus.ctrl_shiftop;
               w_state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (r_rem != 5'd0) begin
               if (r_op)
                  w_acc_nxt = $signed(r_acc) >>> w_step;
               else
                  w_acc_nxt = r_acc << w_step;
               w_rem_nxt = r_rem & ~w_step;
            end else begin
               w_result_nxt = r_acc;
               w_rdy_nxt    = 1'b1;
               w_state_nxt  = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state  <= IDLE;
         r_acc    <= 32'h0;
         r_rem    <= 5'd0;
         r_op     <= 1'b0;
         r_result <= 32'h0;
         r_rdy    <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_acc    <= w_acc_nxt;
         r_rem    <= w_rem_nxt;
         r_op     <= w_op_nxt;
         r_result <= w_result_nxt;
         r_rdy    <= w_rdy_nxt;
      end
   end

   // busy spans the capture edge to the completion edge, i.e. exactly the SHIFT state.
   assign bus.busy           = (r_state == SHIFT);
   assign bus.data_result    = r_result;
   assign bus.data_resultRDY = r_rdy;

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle shift controller for the ALU shift path. It performs SLL or SRA on a 32-bit operand by a 5-bit amount. Each cycle it applies one power-of-two fixed shift stage (16, 8, 4, 2 or 1), so a small single-stage datapath replaces a full barrel shifter. It sits beside the ALU and uses a start/ready handshake, so the pipeline stalls only while a shift is in flight.

## Interface
- No parameters; width fixed at 32 bits, shift amount at 5 bits.
- clock  input  1  single system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset; clears all state immediately when low.
- ctrl_start  input  1  request; sampled on rising edge while not busy.
- ctrl_shiftop  input  1  0 = SLL (logical left, zero fill), 1 = SRA (arithmetic right, sign fill from bit 31).
- data_operandA  input  32  operand to shift; captured with start.
- ctrl_shiftamt  input  5  shift amount 0..31; captured with start.
- data_result  output  32  shifted result; valid when data_resultRDY high, held until next completion.
- data_resultRDY  output  1  one-cycle completion pulse.
- busy  output  1  high from capture edge until completion edge; requests ignored while high.

## Operation
- Internal state: accumulator acc[31:0], remaining amount rem[4:0], latched op, FSM state.
- FSM states: IDLE, SHIFT.
- IDLE: when ctrl_start=1 at a rising edge:
  - acc <= data_operandA; rem <= ctrl_shiftamt; op <= ctrl_shiftop.
  - busy <= 1; state <= SHIFT.
- SHIFT, rem != 0:
  - Select the highest set bit k of rem (weight 16, 8, 4, 2 or 1).
  - acc <= acc shifted by 2^k in the latched direction; SRA replicates acc[31] into the vacated upper bits, SLL zero-fills the lower bits.
  - Clear bit k of rem; stay in SHIFT.
- SHIFT, rem == 0:
  - data_result <= acc; data_resultRDY <= 1 for one cycle.
  - busy <= 0; state <= IDLE.
- Only one stage is applied per cycle, and the order is always MSB to LSB.
- ctrl_start while busy=1 is ignored; no queuing and no error indication.
- Input changes after the capture edge have no effect on the in-flight operation.
- A shift amount of 0 is legal: the result equals the operand, returned after one cycle.

## Timing
- Reset (reset low, asynchronous) forces state=IDLE, busy=0, data_resultRDY=0, data_result=32'h0, acc=0, rem=0, op=0.
- Reset asserted mid-operation aborts the shift: no RDY pulse is produced and data_result reads 0.
- The first start is accepted at the first rising edge after reset deasserts.
- Latency: let p = popcount(ctrl_shiftamt). data_resultRDY is high in the cycle after edge p+1, counting the capture edge as edge 0.
  - Minimum latency is 1 cycle (amount 0); maximum is 6 cycles (amount 31).
- busy is high for exactly p+1 cycles.
- In the cycle where data_resultRDY=1, state is already IDLE and busy=0.
  - A ctrl_start sampled at the next edge is therefore accepted, allowing back-to-back operations with no dead cycle.
- data_resultRDY is a pulse: it deasserts one cycle after asserting, even if no new start arrives.
- data_result is stable from the completion edge until the next completion edge (or reset).

## Test plan
- Reset check: assert reset low mid-stream -> busy=0, data_resultRDY=0, data_result=0 immediately, without waiting for a clock edge.
- SRA, max amount: A=0x80000000, amt=31, op=1 -> data_result=0xFFFFFFFF; RDY 6 cycles after capture; busy high 6 cycles.
- SLL: A=0x00000001, amt=5, op=0 -> data_result=0x00000020; RDY 3 cycles after capture.
- SRA positive and zero amount:
  - A=0x7FFFFFFF, amt=2, op=1 -> 0x1FFFFFFF after 2 cycles.
  - A=0x12345678, amt=0 -> 0x12345678 after 1 cycle.
- Start while busy: start A=0xF0000000, amt=4, op=1; re-assert start with A=0x1, amt=1 while busy -> only 0xFF000000 returned, single RDY pulse.
  - Then issue start in the RDY cycle (A=0x3, amt=1, op=0) -> accepted; 0x6 returned 2 cycles later.
- Reset mid-op: start amt=31, pull reset low after 2 cycles, release -> no RDY pulse, data_result=0.
  - A new start then completes normally.
